// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port memory between instruction fetch and
//            load/store, one transaction in flight, fixed access latency.
// Options  : MEM_ARB_ROUND_ROBIN_EN - round-robin tie-break (else data wins)
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LATENCY    = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic [DATA_WIDTH-1:0] if_rdata,
   output logic                  if_ack,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  d_ack,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   localparam logic [3:0] C_CNT_INIT = 4'(LATENCY - 1);

   state_t                r_state;
   logic [3:0]            r_cnt;
   logic                  r_win_d;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_wdata;
   logic                  r_mem_read;
   logic                  r_mem_write;
   logic [DATA_WIDTH-1:0] r_if_rdata;
   logic [DATA_WIDTH-1:0] r_d_rdata;
   logic                  r_if_ack;
   logic                  r_d_ack;
   logic                  w_grant_d;
   logic                  w_d_store;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic                  r_last_d;

   // On a tie, serve whichever side did not win the previous grant.
   assign w_grant_d = d_req & (~if_req | ~r_last_d);
`else
   assign w_grant_d = d_req;
`endif

   assign w_d_store = w_grant_d & d_we;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 4'd0;
         r_win_d     <= 1'b0;
         r_we        <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_if_rdata  <= '0;
         r_d_rdata   <= '0;
         r_if_ack    <= 1'b0;
         r_d_ack     <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         r_last_d    <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (d_req || if_req) begin
                  r_win_d     <= w_grant_d;
                  r_we        <= w_d_store;
                  r_mem_addr  <= w_grant_d ? d_addr : if_addr;
                  r_mem_wdata <= w_grant_d ? d_wdata : '0;
                  r_mem_read  <= ~w_d_store;
                  r_mem_write <= w_d_store;
                  r_cnt       <= C_CNT_INIT;
                  r_state     <= ST_ACCESS;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                  r_last_d    <= w_grant_d;
`endif
               end
            end
            ST_ACCESS: begin
               // A store strobes the write only in its first access cycle.
               r_mem_write <= 1'b0;
               if (r_cnt == 4'd0) begin
                  r_mem_read <= 1'b0;
                  r_state    <= ST_RESP;
                  if (r_win_d) begin
                     r_d_rdata <= r_we ? '0 : mem_rdata;
                     r_d_ack   <= 1'b1;
                  end else begin
                     r_if_rdata <= mem_rdata;
                     r_if_ack   <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_RESP: begin
               r_if_ack <= 1'b0;
               r_d_ack  <= 1'b0;
               r_state  <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign if_rdata  = r_if_rdata;
   assign if_ack    = r_if_ack;
   assign d_rdata   = r_d_rdata;
   assign d_ack     = r_d_ack;
   assign mem_addr  = r_mem_addr;
   assign mem_read  = r_mem_read;
   assign mem_write = r_mem_write;
   assign mem_wdata = r_mem_wdata;
   assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed scoreboard bench for mem_port_arbiter (LATENCY = 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

   localparam int LAT = 3;

   logic        clock = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ack;
   logic [31:0] mem_addr;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy;

   typedef struct packed {
      logic        is_d;
      logic [31:0] data;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] mem [0:255];
   bit          loaded = 1'b0;
   int          n_tests = 0;
   int          n_fail = 0;
   int          cyc = 0;

   mem_port_arbiter #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .LATENCY   (LAT)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_rdata (if_rdata),
      .if_ack   (if_ack),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_rdata  (d_rdata),
      .d_ack    (d_ack),
      .mem_addr (mem_addr),
      .mem_read (mem_read),
      .mem_write(mem_write),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .busy     (busy)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Word-addressed memory model with combinational read.
   always @(posedge clock) begin
      if (!loaded) begin
         mem[4]  <= 32'hDEAD_BEEF;
         mem[8]  <= 32'h0000_0000;
         mem[16] <= 32'hCAFE_F00D;
         loaded  <= 1'b1;
      end else if (mem_write) begin
         mem[mem_addr[9:2]] <= mem_wdata;
      end
   end
   assign mem_rdata = mem[mem_addr[9:2]];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic expect_ack(input logic is_d, input logic [31:0] data);
      exp_t e;
      e.is_d = is_d;
      e.data = data;
      sb_q.push_back(e);
   endtask

   // Scoreboard monitor: every ack pops one expected response.
   always @(negedge clock) begin
      if (if_ack && d_ack) begin
         n_tests++;
         n_fail++;
         $display("FAIL ack_exclusive: if_ack=%b d_ack=%b, expected at most one high", if_ack, d_ack);
      end else if (if_ack || d_ack) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_ack: if_ack=%b d_ack=%b, expected no ack", if_ack, d_ack);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("ack_port_is_data", {31'b0, d_ack}, {31'b0, e.is_d});
            check("ack_rdata", d_ack ? d_rdata : if_rdata, e.data);
         end
      end
   end

   task automatic wait_ack(output int at);
      int n;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!(if_ack || d_ack) && n < 60);
      if (!(if_ack || d_ack)) begin
         n_tests++;
         n_fail++;
         $display("FAIL ack_timeout: no ack within %0d cycles, expected one", n);
      end
      at = cyc;
   endtask

   // Single request; called #1 after a rising edge.
   task automatic issue(input logic is_d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd);
      int  start;
      int  n;
      int  rd_cnt;
      int  wr_cnt;
      bit  addr_ok;
      bit  seen;
      n = 0; rd_cnt = 0; wr_cnt = 0; addr_ok = 1'b1; seen = 1'b0;
      expect_ack(is_d, exp_rd);
      if (is_d) begin
         d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      start = cyc;
      while (!seen && n < 60) begin
         @(negedge clock);
         n++;
         if (cyc - start == 1) begin
            if (is_d) begin
               d_addr = ~addr; d_wdata = ~wdata; d_we = ~we;
            end else begin
               if_addr = ~addr;
            end
         end
         if (mem_read)  rd_cnt++;
         if (mem_write) wr_cnt++;
         if ((mem_read || mem_write) && mem_addr !== addr) addr_ok = 1'b0;
         seen = is_d ? d_ack : if_ack;
      end
      check("req_to_ack_edges", cyc - start, LAT + 1);
      check("mem_read_cycles", rd_cnt, we ? 0 : LAT);
      check("mem_write_cycles", wr_cnt, we ? 1 : 0);
      check("mem_addr_latched", {31'b0, addr_ok}, 32'd1);
      @(posedge clock);
      #1;
      if (is_d) d_req = 1'b0; else if_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int at;
      int prev;
      int acks;

      reset = 1'b1;
      if_req = 1'b1; if_addr = 32'h10;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_wdata = 32'h0;

      // Reset held two edges with both requests pending.
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_if_ack", {31'b0, if_ack}, 32'd0);
      check("rst_d_ack", {31'b0, d_ack}, 32'd0);
      check("rst_mem_read", {31'b0, mem_read}, 32'd0);
      check("rst_mem_write", {31'b0, mem_write}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_if_rdata", if_rdata, 32'd0);
      check("rst_d_rdata", d_rdata, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);

      expect_ack(1'b1, 32'hCAFE_F00D);
      expect_ack(1'b0, 32'hDEAD_BEEF);
      reset = 1'b0;
      @(negedge clock);
      check("first_grant_busy", {31'b0, busy}, 32'd1);
      wait_ack(at);
      @(posedge clock); #1 d_req = 1'b0;
      wait_ack(at);
      @(posedge clock); #1 if_req = 1'b0;

      issue(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);
      issue(1'b1, 1'b1, 32'h20, 32'h1234_5678, 32'h0);
      issue(1'b1, 1'b0, 32'h20, 32'h0, 32'h1234_5678);
      check("if_rdata_hold", if_rdata, 32'hDEAD_BEEF);

      // Both requesters held continuously.
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
      if_req = 1'b1; if_addr = 32'h10;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      expect_ack(1'b1, 32'h1234_5678);
      expect_ack(1'b0, 32'hDEAD_BEEF);
      expect_ack(1'b1, 32'h1234_5678);
      expect_ack(1'b0, 32'hDEAD_BEEF);
`else
      expect_ack(1'b1, 32'h1234_5678);
      expect_ack(1'b1, 32'h1234_5678);
      expect_ack(1'b1, 32'h1234_5678);
      expect_ack(1'b0, 32'hDEAD_BEEF);
`endif
      prev = 0;
      for (int k = 0; k < 4; k++) begin
         wait_ack(at);
         if (k > 0) check("tie_ack_spacing", at - prev, LAT + 2);
         prev = at;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         if (k == 3) begin
            @(posedge clock); #1 d_req = 1'b0; if_req = 1'b0;
         end
`else
         if (k == 2) begin
            @(posedge clock); #1 d_req = 1'b0;
         end
         if (k == 3) begin
            @(posedge clock); #1 if_req = 1'b0;
         end
`endif
      end

      // Reset during the second access cycle of a fetch.
      if_req = 1'b1; if_addr = 32'h10;
      @(posedge clock);
      @(posedge clock);
      #1 reset = 1'b1; if_req = 1'b0;
      @(negedge clock);
      check("mid_access_mem_read", {31'b0, mem_read}, 32'd1);
      @(negedge clock);
      check("post_rst_mem_read", {31'b0, mem_read}, 32'd0);
      check("post_rst_busy", {31'b0, busy}, 32'd0);
      check("post_rst_if_rdata", if_rdata, 32'd0);
      reset = 1'b0;
      acks = 0;
      repeat (LAT + 3) begin
         @(negedge clock);
         if (if_ack || d_ack) acks++;
      end
      check("no_ack_after_drop", acks, 0);
      @(posedge clock); #1;
      issue(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);
      issue(1'b1, 1'b0, 32'h40, 32'h0, 32'hCAFE_F00D);

      repeat (2) @(negedge clock);
      check("scoreboard_drained", sb_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
